// File: rtl/vga_src_if.sv
// Address/colour link between the VGA scan controller and an image source.
// The source registers the colour for the presented address on the shared pixel tick.
interface vga_src_if #(
  parameter int unsigned COL_BITS = 4
) ();
  logic [9:0]          addr_row;
  logic [9:0]          addr_col;
  logic [COL_BITS-1:0] col_r;
  logic [COL_BITS-1:0] col_g;
  logic [COL_BITS-1:0] col_b;

  modport ctrl (
    output addr_row,
    output addr_col,
    input  col_r,
    input  col_g,
    input  col_b
  );

  modport mem (
    input  addr_row,
    input  addr_col,
    output col_r,
    output col_g,
    output col_b
  );
endinterface

// File: rtl/vga_scan_ctrl.sv
// VGA scan controller: raster counters, per-axis phase FSMs and a two-stage pixel pipeline
// that keeps colour and syncs aligned at the pins.
module vga_scan_ctrl #(
  parameter int unsigned COL_BITS = 4,
  parameter int unsigned H_VIS    = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_VIS    = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter logic        SYNC_ACT = 1'b0
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  input  logic                i_en,
  vga_src_if.ctrl             io,
  output logic                o_hsync,
  output logic                o_vsync,
  output logic [COL_BITS-1:0] o_r,
  output logic [COL_BITS-1:0] o_g,
  output logic [COL_BITS-1:0] o_b,
  output logic                o_frame_start
);

  localparam logic [1:0] StVis  = 2'd0;
  localparam logic [1:0] StFp   = 2'd1;
  localparam logic [1:0] StSync = 2'd2;
  localparam logic [1:0] StBp   = 2'd3;

  // Last counter value of each segment
  localparam logic [9:0] HEndVis  = 10'(H_VIS - 1);
  localparam logic [9:0] HEndFp   = 10'(H_VIS + H_FP - 1);
  localparam logic [9:0] HEndSync = 10'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [9:0] HEndBp   = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] VEndVis  = 10'(V_VIS - 1);
  localparam logic [9:0] VEndFp   = 10'(V_VIS + V_FP - 1);
  localparam logic [9:0] VEndSync = 10'(V_VIS + V_FP + V_SYNC - 1);
  localparam logic [9:0] VEndBp   = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);

  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;
  logic [1:0] h_st_q, h_st_d;
  logic [1:0] v_st_q, v_st_d;
  logic       h_wrap;

  logic       vis_d1, hs_d1, vs_d1, fs_d1;

  always_comb begin
    h_wrap  = (h_cnt_q == HEndBp);
    h_cnt_d = h_wrap ? 10'd0 : h_cnt_q + 10'd1;
    v_cnt_d = v_cnt_q;
    if (h_wrap) begin
      v_cnt_d = (v_cnt_q == VEndBp) ? 10'd0 : v_cnt_q + 10'd1;
    end

    h_st_d = h_st_q;
    case (h_st_q)
      StVis:   if (h_cnt_q == HEndVis)  h_st_d = StFp;
      StFp:    if (h_cnt_q == HEndFp)   h_st_d = StSync;
      StSync:  if (h_cnt_q == HEndSync) h_st_d = StBp;
      StBp:    if (h_cnt_q == HEndBp)   h_st_d = StVis;
      default: h_st_d = StVis;
    endcase

    // Vertical phase only moves on the line wrap
    v_st_d = v_st_q;
    if (h_wrap) begin
      case (v_st_q)
        StVis:   if (v_cnt_q == VEndVis)  v_st_d = StFp;
        StFp:    if (v_cnt_q == VEndFp)   v_st_d = StSync;
        StSync:  if (v_cnt_q == VEndSync) v_st_d = StBp;
        StBp:    if (v_cnt_q == VEndBp)   v_st_d = StVis;
        default: v_st_d = StVis;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      h_st_q  <= StVis;
      v_st_q  <= StVis;
    end else if (i_en) begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      h_st_q  <= h_st_d;
      v_st_q  <= v_st_d;
    end
  end

  assign io.addr_col = (h_st_q == StVis) ? h_cnt_q : 10'd0;
  assign io.addr_row = (v_st_q == StVis) ? v_cnt_q : 10'd0;

  // Stage 1: the source captures its colour on this same tick
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      vis_d1 <= 1'b0;
      hs_d1  <= 1'b0;
      vs_d1  <= 1'b0;
      fs_d1  <= 1'b0;
    end else if (i_en) begin
      vis_d1 <= (h_st_q == StVis) && (v_st_q == StVis);
      hs_d1  <= (h_st_q == StSync);
      vs_d1  <= (v_st_q == StSync);
      fs_d1  <= (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
    end
  end

  // Stage 2: pins
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_r     <= '0;
      o_g     <= '0;
      o_b     <= '0;
      o_hsync <= ~SYNC_ACT;
      o_vsync <= ~SYNC_ACT;
    end else if (i_en) begin
      o_r     <= vis_d1 ? io.col_r : '0;
      o_g     <= vis_d1 ? io.col_g : '0;
      o_b     <= vis_d1 ? io.col_b : '0;
      o_hsync <= hs_d1 ? SYNC_ACT : ~SYNC_ACT;
      o_vsync <= vs_d1 ? SYNC_ACT : ~SYNC_ACT;
    end
  end

  // Updated every clock so the pulse lasts exactly one cycle even with a slow tick
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_frame_start <= 1'b0;
    end else begin
      o_frame_start <= fs_d1 & i_en;
    end
  end

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Randomized bench for vga_scan_ctrl with shrunk timing parameters; a raster model derives
// every expected pin and address value from the count of pixel ticks since reset.
module tb_vga_scan_ctrl;

  localparam int unsigned HV = 20, HF = 3, HS = 5, HB = 4;
  localparam int unsigned VV = 12, VF = 2, VS = 2, VB = 3;
  localparam int unsigned HT = HV + HF + HS + HB;
  localparam int unsigned VT = VV + VF + VS + VB;
  localparam int unsigned FT = HT * VT;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       en = 1'b0;
  logic       hsync, vsync, frame_start;
  logic [3:0] r, g, b;

  always #5 clk = ~clk;

  vga_src_if #(.COL_BITS(4)) bus ();

  vga_scan_ctrl #(
    .COL_BITS (4),
    .H_VIS    (HV),
    .H_FP     (HF),
    .H_SYNC   (HS),
    .H_BP     (HB),
    .V_VIS    (VV),
    .V_FP     (VF),
    .V_SYNC   (VS),
    .V_BP     (VB),
    .SYNC_ACT (1'b0)
  ) dut (
    .i_clk         (clk),
    .i_rstn        (rstn),
    .i_en          (en),
    .io            (bus.ctrl),
    .o_hsync       (hsync),
    .o_vsync       (vsync),
    .o_r           (r),
    .o_g           (g),
    .o_b           (b),
    .o_frame_start (frame_start)
  );

  // Stub image source: random lookup tables, one-tick registered read
  logic [3:0] lut_r [1024];
  logic [3:0] lut_g [1024];
  logic [3:0] lut_b [1024];

  always @(posedge clk) begin
    if (en) begin
      bus.col_r <= lut_r[bus.addr_col];
      bus.col_g <= lut_g[bus.addr_row];
      bus.col_b <= lut_b[bus.addr_col ^ bus.addr_row];
    end
  end

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  int unsigned n_en = 0;   // pixel ticks since reset release
  bit          last_en = 1'b0;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (tick %0d, t=%0t)", tag, got, exp, n_en,
               $time);
    end
  endtask

  task automatic check_outputs();
    int unsigned c, h, v, p, ph, pv, exp_rgb;
    c = n_en % FT;
    h = c % HT;
    v = c / HT;
    check_eq("addr_col", bus.addr_col, (h < HV) ? h : 0);
    check_eq("addr_row", bus.addr_row, (v < VV) ? v : 0);
    if (n_en < 2) begin
      check_eq("rgb_rst", {r, g, b}, 0);
      check_eq("hsync_rst", hsync, 1);
      check_eq("vsync_rst", vsync, 1);
      check_eq("fs_rst", frame_start, 0);
    end else begin
      p  = (n_en - 2) % FT;
      ph = p % HT;
      pv = p / HT;
      exp_rgb = 0;
      if (ph < HV && pv < VV) exp_rgb = {lut_r[ph], lut_g[pv], lut_b[ph ^ pv]};
      check_eq("rgb", {r, g, b}, exp_rgb);
      check_eq("hsync", hsync, (ph >= HV + HF && ph < HV + HF + HS) ? 0 : 1);
      check_eq("vsync", vsync, (pv >= VV + VF && pv < VV + VF + VS) ? 0 : 1);
      check_eq("frame_start", frame_start, (last_en && p == 0) ? 1 : 0);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rstn && en) n_en++;
    last_en = rstn && en;
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      lut_r[i] = 4'($urandom);
      lut_g[i] = 4'($urandom);
      lut_b[i] = 4'($urandom);
    end
    bus.col_r = '0;
    bus.col_g = '0;
    bus.col_b = '0;

    // Reset held while the tick toggles
    for (int i = 0; i < 8; i++) begin
      en = 1'($urandom);
      step();
    end
    rstn = 1'b1;

    // Tick every cycle for two frames
    en = 1'b1;
    for (int i = 0; i < 2 * FT + 10; i++) step();

    // Tick one cycle in four
    for (int i = 0; i < 4 * FT; i++) begin
      en = (i % 4 == 0);
      step();
    end

    // Random tick density, then reset mid-frame
    for (int i = 0; i < 300 + int'($urandom_range(0, 40)); i++) begin
      en = ($urandom_range(0, 2) != 0);
      step();
    end
    rstn = 1'b0;
    #1;
    n_en = 0;
    last_en = 1'b0;
    check_outputs();
    for (int i = 0; i < 3; i++) begin
      en = 1'($urandom);
      step();
    end
    rstn = 1'b1;
    for (int i = 0; i < 3 * FT; i++) begin
      en = ($urandom_range(0, 2) != 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
